// File: rtl/dcache_pkg.sv
// Shared constants and flush FSM state type for the data cache tag/valid array.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package dcache_pkg;

    localparam int NUM_WAYS = 8;
    localparam int NUM_SETS = 64;
    localparam int TAG_W    = 44;
    localparam int INDEX_W  = 6;
    localparam int WAY_W    = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_t;

endpackage

// File: rtl/dcache_way_store.sv
// One cache way: 64 tag entries plus 64 valid bits, one write port, one set-clear port.
// Latency: read is combinational from rd_index; writes/clears visible the cycle after the edge.
// Backpressure: none; the caller gates writes and holds rd_index.
module dcache_way_store
    import dcache_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               wen,
    input  logic [INDEX_W-1:0] windex,
    input  logic [TAG_W-1:0]   wtag,
    input  logic               wvalid,
    input  logic               clr_en,
    input  logic [INDEX_W-1:0] clr_index,
    input  logic [INDEX_W-1:0] rd_index,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid
);

    logic [TAG_W-1:0]    tag_mem [NUM_SETS];
    logic [NUM_SETS-1:0] valid_mem;

    // Tag storage: written only by the control port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                tag_mem[s] <= '0;
            end
        end else if (wen) begin
            tag_mem[windex] <= wtag;
        end
    end

    // Valid bits: flush clear wins over a write (the top never issues both together).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_mem <= '0;
        end else if (clr_en) begin
            valid_mem[clr_index] <= 1'b0;
        end else if (wen) begin
            valid_mem[windex] <= wvalid;
        end
    end

    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid_mem[rd_index];

endmodule

// File: rtl/dcache_tag_valid_array.sv
// 8-way x 64-set tag/valid array with held read index and sequential flush engine.
// Latency: read data appears the cycle after accept; flush takes 64 cycles, done pulses the cycle after.
// Backpressure: read index only recaptured on valid && ready, so outputs hold while ready is low.
module dcache_tag_valid_array
    import dcache_pkg::*;
#(
    parameter int NUM_WAYS = dcache_pkg::NUM_WAYS,
    parameter int NUM_SETS = dcache_pkg::NUM_SETS,
    parameter int TAG_W    = dcache_pkg::TAG_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      lookup2array_valid,
    input  logic [INDEX_W-1:0]        lookup2array_index,
    input  logic                      lookup2array_ready,
    output logic [NUM_WAYS*TAG_W-1:0] array2lookup_tag,
    output logic [NUM_WAYS-1:0]       array2lookup_vbits,
    input  logic                      ctrl2array_wen,
    input  logic [INDEX_W-1:0]        ctrl2array_windex,
    input  logic [WAY_W-1:0]          ctrl2array_wway,
    input  logic [TAG_W-1:0]          ctrl2array_wtag,
    input  logic                      ctrl2array_wvalid,
    input  logic                      ctrl2array_flush,
    output logic                      array2ctrl_busy,
    output logic                      array2ctrl_flush_done
);

    localparam logic [INDEX_W-1:0] CNT_LAST = '1;

    flush_state_t       state_q, state_d;
    logic [INDEX_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [INDEX_W-1:0] idx_q;
    logic [NUM_WAYS-1:0] vbits_raw;
    logic               busy;
    logic               wr_en;

    assign busy  = (state_q == ST_FLUSH);
    assign wr_en = ctrl2array_wen && !busy;

    // Read index register: advances only on a handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
        end else if (lookup2array_valid && lookup2array_ready) begin
            idx_q <= lookup2array_index;
        end
    end

    // Flush FSM state, sweep counter and done pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Flush FSM next state: one set per cycle, done pulses after the last set.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ctrl2array_flush) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        dcache_way_store u_way (
            .clock     (clock),
            .reset     (reset),
            .wen       (wr_en && (ctrl2array_wway == WAY_W'(w))),
            .windex    (ctrl2array_windex),
            .wtag      (ctrl2array_wtag),
            .wvalid    (ctrl2array_wvalid),
            .clr_en    (busy),
            .clr_index (cnt_q),
            .rd_index  (idx_q),
            .rd_tag    (array2lookup_tag[w*TAG_W +: TAG_W]),
            .rd_valid  (vbits_raw[w])
        );
    end

    // The whole cache reads as invalid while a sweep is in progress.
    assign array2lookup_vbits    = busy ? '0 : vbits_raw;
    assign array2ctrl_busy       = busy;
    assign array2ctrl_flush_done = done_q;

endmodule

// File: tb/tb_dcache_tag_valid_array.sv
module tb_dcache_tag_valid_array;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         lookup2array_valid = 1'b0;
    logic [5:0]   lookup2array_index = '0;
    logic         lookup2array_ready = 1'b1;
    logic [351:0] array2lookup_tag;
    logic [7:0]   array2lookup_vbits;
    logic         ctrl2array_wen = 1'b0;
    logic [5:0]   ctrl2array_windex = '0;
    logic [2:0]   ctrl2array_wway = '0;
    logic [43:0]  ctrl2array_wtag = '0;
    logic         ctrl2array_wvalid = 1'b0;
    logic         ctrl2array_flush = 1'b0;
    logic         array2ctrl_busy;
    logic         array2ctrl_flush_done;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    dcache_tag_valid_array dut (
        .clock                 (clock),
        .reset                 (reset),
        .lookup2array_valid    (lookup2array_valid),
        .lookup2array_index    (lookup2array_index),
        .lookup2array_ready    (lookup2array_ready),
        .array2lookup_tag      (array2lookup_tag),
        .array2lookup_vbits    (array2lookup_vbits),
        .ctrl2array_wen        (ctrl2array_wen),
        .ctrl2array_windex     (ctrl2array_windex),
        .ctrl2array_wway       (ctrl2array_wway),
        .ctrl2array_wtag       (ctrl2array_wtag),
        .ctrl2array_wvalid     (ctrl2array_wvalid),
        .ctrl2array_flush      (ctrl2array_flush),
        .array2ctrl_busy       (array2ctrl_busy),
        .array2ctrl_flush_done (array2ctrl_flush_done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [351:0] obs, input logic [351:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    task automatic do_write(input logic [5:0] idx, input logic [2:0] way,
                            input logic [43:0] tag, input logic v);
        ctrl2array_wen    = 1'b1;
        ctrl2array_windex = idx;
        ctrl2array_wway   = way;
        ctrl2array_wtag   = tag;
        ctrl2array_wvalid = v;
        tick();
        ctrl2array_wen    = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] idx);
        lookup2array_valid = 1'b1;
        lookup2array_ready = 1'b1;
        lookup2array_index = idx;
        tick();
        lookup2array_valid = 1'b0;
    endtask

    function automatic logic [43:0] fill_tag(input int s, input int w);
        return 44'hA00_0000_0000 | 44'(s << 8) | 44'(w);
    endfunction

    logic [351:0] exp_tag;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_tag", array2lookup_tag, '0);
        chk("rst_vbits", 352'(array2lookup_vbits), 352'(8'h00));
        chk("rst_busy", 352'(array2ctrl_busy), 352'(1'b0));
        chk("rst_done", 352'(array2ctrl_flush_done), 352'(1'b0));
        reset = 1'b0;
        tick();

        // Read of an empty set
        do_read(6'd5);
        chk("empty_vbits", 352'(array2lookup_vbits), 352'(8'h00));
        chk("empty_tag", array2lookup_tag, '0);

        // Write set 5 way 3, visible on the held index the cycle after
        do_write(6'd5, 3'd3, 44'h0AB_CDEF_1234, 1'b1);
        exp_tag = '0;
        exp_tag[175:132] = 44'h0AB_CDEF_1234;
        chk("w3_vbits", 352'(array2lookup_vbits), 352'(8'h08));
        chk("w3_tag", array2lookup_tag, exp_tag);

        // Hold ready low with a pending request to set 7; write set 5 way 0
        lookup2array_ready = 1'b0;
        lookup2array_valid = 1'b1;
        lookup2array_index = 6'd7;
        chk("hold_pre_vbits", 352'(array2lookup_vbits), 352'(8'h08));
        do_write(6'd5, 3'd0, 44'h000_0000_0111, 1'b1);
        exp_tag[43:0] = 44'h000_0000_0111;
        for (int i = 0; i < 9; i++) begin
            chk("hold_vbits", 352'(array2lookup_vbits), 352'(8'h09));
            chk("hold_tag", array2lookup_tag, exp_tag);
            tick();
        end
        lookup2array_valid = 1'b0;
        lookup2array_ready = 1'b1;

        // Invalidate one line
        do_write(6'd5, 3'd3, 44'h0AB_CDEF_1234, 1'b0);
        chk("inval_vbits", 352'(array2lookup_vbits), 352'(8'h01));

        // Fill all ways of sets 0 and 63
        for (int w = 0; w < 8; w++) begin
            do_write(6'd0, 3'(w), fill_tag(0, w), 1'b1);
            do_write(6'd63, 3'(w), fill_tag(63, w), 1'b1);
        end
        do_read(6'd63);
        exp_tag = '0;
        for (int w = 0; w < 8; w++) exp_tag[44*w +: 44] = fill_tag(63, w);
        chk("fill63_vbits", 352'(array2lookup_vbits), 352'(8'hFF));
        chk("fill63_tag", array2lookup_tag, exp_tag);
        do_read(6'd0);
        exp_tag = '0;
        for (int w = 0; w < 8; w++) exp_tag[44*w +: 44] = fill_tag(0, w);
        chk("fill0_vbits", 352'(array2lookup_vbits), 352'(8'hFF));

        // Flush in cycle t
        ctrl2array_flush = 1'b1;
        chk("flush_t_busy", 352'(array2ctrl_busy), 352'(1'b0));
        tick();
        ctrl2array_flush = 1'b0;
        // Cycles t+1 .. t+64
        for (int i = 1; i <= 64; i++) begin
            if (i == 1) begin
                chk("flush_vbits_forced", 352'(array2lookup_vbits), 352'(8'h00));
                chk("flush_tag_driven", array2lookup_tag, exp_tag);
                ctrl2array_wen    = 1'b1;
                ctrl2array_windex = 6'd10;
                ctrl2array_wway   = 3'd2;
                ctrl2array_wtag   = 44'h123_4567_89AB;
                ctrl2array_wvalid = 1'b1;
            end
            if (i == 2) ctrl2array_wen = 1'b0;
            ctrl2array_flush = (i == 30);
            chk("flush_busy", 352'(array2ctrl_busy), 352'(1'b1));
            chk("flush_done_low", 352'(array2ctrl_flush_done), 352'(1'b0));
            tick();
        end
        ctrl2array_flush = 1'b0;
        // Cycle t+65: done pulse, idle; issue write + new flush together
        chk("t65_busy", 352'(array2ctrl_busy), 352'(1'b0));
        chk("t65_done", 352'(array2ctrl_flush_done), 352'(1'b1));
        chk("t65_vbits", 352'(array2lookup_vbits), 352'(8'h00));
        ctrl2array_flush = 1'b1;
        do_write(6'd40, 3'd1, 44'h0FE_DCBA_9876, 1'b1);
        ctrl2array_flush = 1'b0;
        // Cycle t+66: second flush running
        chk("t66_busy", 352'(array2ctrl_busy), 352'(1'b1));
        chk("t66_done", 352'(array2ctrl_flush_done), 352'(1'b0));

        // Reads during busy still captured; tags driven, vbits forced
        do_read(6'd40);
        exp_tag = '0;
        exp_tag[87:44] = 44'h0FE_DCBA_9876;
        chk("busy_read_tag", array2lookup_tag, exp_tag);
        chk("busy_read_vbits", 352'(array2lookup_vbits), 352'(8'h00));
        // Now in busy cycle 2; advance to busy cycle 20
        for (int i = 0; i < 18; i++) tick();
        chk("pre_rst_busy", 352'(array2ctrl_busy), 352'(1'b1));
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", 352'(array2ctrl_busy), 352'(1'b0));
        chk("rst_mid_done", 352'(array2ctrl_flush_done), 352'(1'b0));
        chk("rst_mid_tag", array2lookup_tag, '0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 70; i++) begin
            chk("no_done_after_rst", 352'(array2ctrl_flush_done), 352'(1'b0));
            chk("idle_after_rst", 352'(array2ctrl_busy), 352'(1'b0));
            tick();
        end

        // All sets read invalid after first flush / reset
        do_read(6'd0);
        chk("post_set0_vbits", 352'(array2lookup_vbits), 352'(8'h00));
        do_read(6'd63);
        chk("post_set63_vbits", 352'(array2lookup_vbits), 352'(8'h00));
        do_read(6'd5);
        chk("post_set5_vbits", 352'(array2lookup_vbits), 352'(8'h00));
        do_read(6'd10);
        chk("dropped_vbits", 352'(array2lookup_vbits), 352'(8'h00));
        chk("dropped_tag", array2lookup_tag, '0);
        do_read(6'd40);
        chk("post_set40_vbits", 352'(array2lookup_vbits), 352'(8'h00));

        // Writes work again after reset
        do_write(6'd40, 3'd7, 44'h001_0000_0001, 1'b1);
        chk("post_write_vbits", 352'(array2lookup_vbits), 352'(8'h80));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dcache_tag_valid_array.md
# dcache_tag_valid_array

Tag and valid storage for the 8-way, 64-set data cache, answering the per-set read requests issued by the lookup stage and accepting tag/valid updates from the cache control FSM. A registered read index returns all eight 44-bit tags and eight valid bits of one set per request, held under downstream back-pressure. A sequential flush engine invalidates the whole cache one set per cycle.

## Interface
Parameters:
- NUM_WAYS, 8, ways per set (fixed; tag bus width = NUM_WAYS*TAG_W)
- NUM_SETS, 64, sets; index width 6
- TAG_W, 44, physical tag width

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- lookup2array_valid  in  1  read request valid
- lookup2array_index  in  6  set to read
- lookup2array_ready  in  1  lookup stage accepts the current read data; request captured only when valid && ready
- array2lookup_tag  out  352  tags of the held set; way w at [44w+43:44w]
- array2lookup_vbits  out  8  valid bits of the held set; bit w = way w
- ctrl2array_wen  in  1  write strobe
- ctrl2array_windex  in  6  set to write
- ctrl2array_wway  in  3  way to write
- ctrl2array_wtag  in  44  tag value written
- ctrl2array_wvalid  in  1  valid bit value written (0 = invalidate one line)
- ctrl2array_flush  in  1  start whole-cache invalidate (level sampled in IDLE)
- array2ctrl_busy  out  1  flush in progress
- array2ctrl_flush_done  out  1  one-cycle pulse when flush completes

## Operation
- Read: idx_q <= lookup2array_index on clock edge when lookup2array_valid && lookup2array_ready; otherwise idx_q holds. Outputs are a combinational view of storage[idx_q], so data stays stable while ready is low.
- A write to the held set is visible on the outputs the cycle after the write edge (write-then-read through the same flops; no extra bypass).
- Write: on edge with ctrl2array_wen && !busy: tag[windex][wway] <= wtag, valid[windex][wway] <= wvalid. Other ways untouched. Writes while busy are dropped.
- FSM: IDLE, FLUSH. IDLE -> FLUSH when ctrl2array_flush, cnt <= 0. In FLUSH each edge clears all 8 valid bits of set cnt, cnt++; at cnt==63 -> IDLE and flush_done asserted next cycle. Flush request while in FLUSH ignored.
- While busy, array2lookup_vbits forced to 0 (whole cache treated invalid); tags still driven. Reads still captured normally.
- Flush and write in same IDLE cycle: write performed, sweep starts next cycle and eventually clears it.

## Timing
- Reset: all valid bits 0, all tags 0, idx_q 0, state IDLE, cnt 0; outputs array2lookup_tag 0, array2lookup_vbits 0, busy 0, flush_done 0.
- Read latency: request accepted at edge of cycle t -> data on outputs in cycle t+1, held until next accept.
- Flush asserted in cycle t (IDLE): busy high cycles t+1..t+64; set k cleared at end of cycle t+1+k; flush_done high only in cycle t+65, busy low there; new flush accepted from t+65.
- Reset mid-flush: returns to IDLE immediately, all valid 0, no flush_done pulse.
- cnt is 6 bits; terminal compare at 63, no wrap beyond.

## Structure
- Shared dcache_pkg: NUM_WAYS, NUM_SETS, TAG_W, INDEX_W=6, WAY_W=3, flush FSM state enum.
- One sub-module dcache_way_store: one way's 64x44 tag flops + 64 valid flops, write port, flush-clear port, combinational read at idx_q; instantiated 8 times, way select decoded from wway.

## Test plan
- Reset then read index 5 -> vbits 8'h00, tag all zero in cycle after accept.
- Write set 5 way 3 tag 44'h0AB_CDEF_1234 valid 1, read set 5 -> vbits 8'h08, tag[175:132]=44'h0AB_CDEF_1234.
- Accept read of set 5, hold ready low 10 cycles while writing set 5 way 0 -> vbits changes 8'h08 -> 8'h09 one cycle after write, index not re-captured with ready low.
- Fill ways 0..7 of sets 0 and 63, flush at cycle t -> busy t+1..t+64, flush_done only at t+65, then reads of sets 0 and 63 return 8'h00.
- Write asserted during busy -> dropped; after flush, target set reads vbits 8'h00.
- Assert reset at flush cycle 20 -> busy 0 immediately, no done pulse, all sets read invalid.
